// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : EX-stage branch/jump resolution for a predict-not-taken RV32I
//            pipeline. Decides taken/not-taken from the ALU flags of rs1-rs2,
//            issues a registered one-cycle PC redirect, holds IF/ID and ID/EX
//            flush for FLUSH_CYCLES cycles, and keeps saturating branch and
//            taken performance counters.
// Ports    : clk, rst (sync, active-high)
//            ex_valid, stall, is_branch, is_jump, funct3    - EX control
//            zero/carry/overflow/sign_flag, rs2_zero        - compare flags
//            target_pc                                      - branch target
//            redirect, redirect_pc                          - fetch redirect
//            flush_if_id, flush_id_ex                       - squash controls
//            illegal_branch                                 - bad funct3 pulse
//            branch_count, taken_count                      - perf counters
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            stall,
    input  logic            is_branch,
    input  logic            is_jump,
    input  logic [2:0]      funct3,
    input  logic            zero_flag,
    input  logic            carry_flag,
    input  logic            overflow_flag,
    input  logic            sign_flag,
    input  logic            rs2_zero,
    input  logic [XLEN-1:0] target_pc,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            illegal_branch,
    output logic [31:0]     branch_count,
    output logic [31:0]     taken_count
);

    localparam logic [0:0] c_ST_RUN     = 1'b0;
    localparam logic [0:0] c_ST_FLUSH   = 1'b1;
    localparam logic [1:0] c_FLUSH_LOAD = 2'(FLUSH_CYCLES);
    localparam logic [31:0] c_CNT_MAX   = 32'hFFFF_FFFF;

    logic [0:0]      r_state;
    logic [1:0]      r_flush_cnt;
    logic            r_redirect;
    logic [XLEN-1:0] r_redirect_pc;
    logic            r_illegal;
    logic [31:0]     r_branch_count;
    logic [31:0]     r_taken_count;

    logic            w_no_borrow;
    logic            w_cond;
    logic            w_bad_code;
    logic            w_eval;
    logic            w_taken;
    logic            w_illegal;

    // The ALU forms rs1 + (-rs2); with rs2 == 0 that add produces no carry
    // even though rs1 >= rs2 always holds, so rs2_zero restores no-borrow.
    assign w_no_borrow = carry_flag | rs2_zero;

    always_comb begin
        w_cond     = 1'b0;
        w_bad_code = 1'b0;
        case (funct3)
            3'b000:  w_cond = zero_flag;
            3'b001:  w_cond = ~zero_flag;
            3'b100:  w_cond = sign_flag ^ overflow_flag;
            3'b101:  w_cond = ~(sign_flag ^ overflow_flag);
            3'b110:  w_cond = ~w_no_borrow;
            3'b111:  w_cond = w_no_borrow;
            default: w_bad_code = 1'b1;  // 010 / 011
        endcase
    end

    // Instructions arriving while a flush is active are the squashed ones.
    assign w_eval    = ex_valid & ~stall & (r_state == c_ST_RUN) & (is_branch | is_jump);
    // A jump wins over any funct3 decode, including the reserved codes.
    assign w_taken   = is_jump | w_cond;
    assign w_illegal = ~is_jump & w_bad_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_ST_RUN;
            r_flush_cnt    <= 2'd0;
            r_redirect     <= 1'b0;
            r_redirect_pc  <= '0;
            r_illegal      <= 1'b0;
            r_branch_count <= 32'd0;
            r_taken_count  <= 32'd0;
        end else begin
            r_redirect <= w_eval & w_taken;
            r_illegal  <= w_eval & w_illegal;

            if (w_eval && w_taken) begin
                r_redirect_pc <= target_pc;
            end

            if (w_eval && is_branch && (r_branch_count != c_CNT_MAX)) begin
                r_branch_count <= r_branch_count + 32'd1;
            end

            if (w_eval && w_taken && (r_taken_count != c_CNT_MAX)) begin
                r_taken_count <= r_taken_count + 32'd1;
            end

            // The flush countdown ignores stall so squashing always ends.
            case (r_state)
                c_ST_RUN: begin
                    if (w_eval && w_taken) begin
                        r_state     <= c_ST_FLUSH;
                        r_flush_cnt <= c_FLUSH_LOAD;
                    end
                end
                c_ST_FLUSH: begin
                    if (r_flush_cnt <= 2'd1) begin
                        r_state     <= c_ST_RUN;
                        r_flush_cnt <= 2'd0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 2'd1;
                    end
                end
                default: begin
                    r_state     <= c_ST_RUN;
                    r_flush_cnt <= 2'd0;
                end
            endcase
        end
    end

    assign redirect       = r_redirect;
    assign redirect_pc    = r_redirect_pc;
    assign flush_if_id    = (r_state == c_ST_FLUSH);
    assign flush_id_ex    = (r_state == c_ST_FLUSH);
    assign illegal_branch = r_illegal;
    assign branch_count   = r_branch_count;
    assign taken_count    = r_taken_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Purpose  : Self-checking bench for branch_resolve_unit. Operands rs1/rs2
//            are generated, the ALU flags are derived from them, and the
//            expected branch outcome is computed from plain relational
//            comparisons of the operands in a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    localparam int FLUSH_CYCLES = 2;
    localparam int XLEN         = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_valid, stall, is_branch, is_jump;
    logic [2:0]      funct3;
    logic            zero_flag, carry_flag, overflow_flag, sign_flag, rs2_zero;
    logic [XLEN-1:0] target_pc;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            flush_if_id, flush_id_ex, illegal_branch;
    logic [31:0]     branch_count, taken_count;

    branch_resolve_unit #(.FLUSH_CYCLES(FLUSH_CYCLES), .XLEN(XLEN)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .stall         (stall),
        .is_branch     (is_branch),
        .is_jump       (is_jump),
        .funct3        (funct3),
        .zero_flag     (zero_flag),
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag),
        .sign_flag     (sign_flag),
        .rs2_zero      (rs2_zero),
        .target_pc     (target_pc),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .illegal_branch(illegal_branch),
        .branch_count  (branch_count),
        .taken_count   (taken_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_flush_left;
    bit          m_redirect, m_illegal;
    bit [31:0]   m_pc, m_bc, m_tc;

    function automatic bit m_flush();
        return (m_flush_left > 0);
    endfunction

    // Drive one cycle of inputs (flags derived from the operands), advance the
    // model by one clock edge, then wait until just after that edge.
    task automatic cycle(input bit v, input bit st, input bit br, input bit jp,
                         input bit [2:0] f3, input bit [31:0] a, input bit [31:0] b,
                         input bit [31:0] tgt, input bit r);
        bit [32:0] sum;
        bit        cond, tk, il, ev;
        sum = {1'b0, a} + {1'b0, (32'd0 - b)};
        rst           = r;
        ex_valid      = v;
        stall         = st;
        is_branch     = br;
        is_jump       = jp;
        funct3        = f3;
        zero_flag     = (sum[31:0] == 32'd0);
        carry_flag    = sum[32];
        sign_flag     = sum[31];
        overflow_flag = (a[31] != b[31]) && (sum[31] != a[31]);
        rs2_zero      = (b == 32'd0);
        target_pc     = tgt;

        if (r) begin
            m_flush_left = 0;
            m_redirect   = 0;
            m_illegal    = 0;
            m_pc         = 0;
            m_bc         = 0;
            m_tc         = 0;
        end else begin
            ev = v && !st && (m_flush_left == 0) && (br || jp);
            case (f3)
                3'd0:    cond = (a == b);
                3'd1:    cond = (a != b);
                3'd4:    cond = ($signed(a) <  $signed(b));
                3'd5:    cond = ($signed(a) >= $signed(b));
                3'd6:    cond = (a <  b);
                3'd7:    cond = (a >= b);
                default: cond = 0;
            endcase
            tk = jp || cond;
            il = !jp && (f3 == 3'd2 || f3 == 3'd3);
            if (m_flush_left > 0) m_flush_left--;
            m_redirect = ev && tk;
            m_illegal  = ev && il;
            if (ev && tk) begin
                m_pc         = tgt;
                m_flush_left = FLUSH_CYCLES;
            end
            if (ev && br && m_bc != 32'hFFFF_FFFF) m_bc++;
            if (ev && tk && m_tc != 32'hFFFF_FFFF) m_tc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        cycle(0, 0, 0, 0, 3'd0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 3'd0, 0, 0, 0, 1);
        n_tests++;
        if ({redirect, redirect_pc, flush_if_id, flush_id_ex, illegal_branch,
             branch_count, taken_count} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got redir=%0b pc=%h fl=%0b%0b ill=%0b bc=%0d tc=%0d, want all zero",
                     redirect, redirect_pc, flush_if_id, flush_id_ex, illegal_branch,
                     branch_count, taken_count);
        end
    endtask

    task automatic test_beq_taken();
        cycle(1, 0, 1, 0, 3'd0, 32'd9, 32'd9, 32'h40, 0);  // cycle N+1
        n_tests++;
        if ({redirect, redirect_pc, flush_if_id, flush_id_ex, branch_count, taken_count}
            !== {1'b1, 32'h40, 1'b1, 1'b1, 32'd1, 32'd1}) begin
            n_fail++;
            $display("FAIL beq_n1: got redir=%0b pc=%h fl=%0b%0b bc=%0d tc=%0d, want 1 00000040 11 1 1",
                     redirect, redirect_pc, flush_if_id, flush_id_ex, branch_count, taken_count);
        end
        // A taken branch offered during the flush must be ignored.
        cycle(1, 0, 1, 0, 3'd0, 32'd1, 32'd1, 32'h80, 0);  // cycle N+2
        n_tests++;
        if ({redirect, flush_if_id, flush_id_ex, redirect_pc} !== {1'b0, 1'b1, 1'b1, 32'h40}) begin
            n_fail++;
            $display("FAIL beq_n2: got redir=%0b fl=%0b%0b pc=%h, want 0 11 00000040",
                     redirect, flush_if_id, flush_id_ex, redirect_pc);
        end
        idle(1);                                            // cycle N+3
        n_tests++;
        if ({flush_if_id, flush_id_ex, taken_count} !== {1'b0, 1'b0, 32'd1}) begin
            n_fail++;
            $display("FAIL beq_n3: got fl=%0b%0b tc=%0d, want 00 1",
                     flush_if_id, flush_id_ex, taken_count);
        end
    endtask

    task automatic test_unsigned_rs2_zero();
        cycle(1, 0, 1, 0, 3'd6, 32'd5, 32'd0, 32'h100, 0);  // BLTU 5 < 0 : no
        n_tests++;
        if ({redirect, flush_if_id} !== {1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL bltu_rs2_zero: got redir=%0b fl=%0b, want 0 0", redirect, flush_if_id);
        end
        cycle(1, 0, 1, 0, 3'd7, 32'd5, 32'd0, 32'h104, 0);  // BGEU 5 >= 0 : yes
        n_tests++;
        if ({redirect, redirect_pc} !== {1'b1, 32'h104}) begin
            n_fail++;
            $display("FAIL bgeu_rs2_zero: got redir=%0b pc=%h, want 1 00000104", redirect, redirect_pc);
        end
        idle(FLUSH_CYCLES);
    endtask

    task automatic test_blt_overflow();
        // sign=1, overflow=1: 0x7FFFFFFF vs -1 -> not less
        cycle(1, 0, 1, 0, 3'd4, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h200, 0);
        n_tests++;
        if (redirect !== 1'b0) begin
            n_fail++;
            $display("FAIL blt_s1_o1: got redir=%0b, want 0", redirect);
        end
        // sign=0, overflow=1: 0x80000000 vs 1 -> less
        cycle(1, 0, 1, 0, 3'd4, 32'h8000_0000, 32'd1, 32'h204, 0);
        n_tests++;
        if ({redirect, redirect_pc} !== {1'b1, 32'h204}) begin
            n_fail++;
            $display("FAIL blt_s0_o1: got redir=%0b pc=%h, want 1 00000204", redirect, redirect_pc);
        end
        idle(FLUSH_CYCLES);
    endtask

    task automatic test_back_to_back();
        bit [31:0] tc0;
        tc0 = m_tc;
        cycle(1, 0, 0, 1, 3'd0, 0, 0, 32'h300, 0);
        cycle(1, 0, 0, 1, 3'd0, 0, 0, 32'h400, 0);
        n_tests++;
        if ({redirect, redirect_pc, taken_count} !== {1'b0, 32'h300, tc0 + 32'd1}) begin
            n_fail++;
            $display("FAIL back_to_back: got redir=%0b pc=%h tc=%0d, want 0 00000300 %0d",
                     redirect, redirect_pc, taken_count, tc0 + 32'd1);
        end
        idle(FLUSH_CYCLES);
    endtask

    task automatic test_illegal();
        bit [31:0] bc0;
        bc0 = m_bc;
        cycle(1, 0, 1, 0, 3'd2, 32'd3, 32'd3, 32'h500, 0);
        n_tests++;
        if ({illegal_branch, redirect, flush_if_id, branch_count} !== {1'b1, 1'b0, 1'b0, bc0 + 32'd1}) begin
            n_fail++;
            $display("FAIL illegal_010: got ill=%0b redir=%0b fl=%0b bc=%0d, want 1 0 0 %0d",
                     illegal_branch, redirect, flush_if_id, branch_count, bc0 + 32'd1);
        end
        idle(1);
        n_tests++;
        if (illegal_branch !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_pulse: got ill=%0b, want 0", illegal_branch);
        end
    endtask

    task automatic test_random();
        bit v, st, br, jp;
        bit [2:0] f3;
        bit [31:0] a, b, tgt;
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(3, 0) != 0);
            st  = ($urandom_range(4, 0) == 0);
            br  = $urandom_range(1, 0);
            jp  = ($urandom_range(5, 0) == 0);
            f3  = 3'($urandom_range(7, 0));
            a   = $urandom;
            case ($urandom_range(3, 0))
                0:       b = a;
                1:       b = 32'd0;
                2:       b = a ^ 32'h8000_0000;
                default: b = $urandom;
            endcase
            tgt = $urandom & 32'hFFFF_FFFC;
            cycle(v, st, br, jp, f3, a, b, tgt, 0);
            n_tests++;
            if ({redirect, redirect_pc, flush_if_id, flush_id_ex, illegal_branch,
                 branch_count, taken_count} !==
                {m_redirect, m_pc, m_flush(), m_flush(), m_illegal, m_bc, m_tc}) begin
                n_fail++;
                $display("FAIL random_%0d: got redir=%0b pc=%h fl=%0b%0b ill=%0b bc=%0d tc=%0d, want %0b %h %0b%0b %0b %0d %0d",
                         i, redirect, redirect_pc, flush_if_id, flush_id_ex, illegal_branch,
                         branch_count, taken_count, m_redirect, m_pc, m_flush(), m_flush(),
                         m_illegal, m_bc, m_tc);
            end
        end
        idle(FLUSH_CYCLES + 1);
    endtask

    task automatic test_saturation_and_reset();
        force dut.r_taken_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_taken_count;
        m_tc = 32'hFFFF_FFFF;
        cycle(1, 0, 0, 1, 3'd0, 0, 0, 32'h600, 0);  // JAL
        n_tests++;
        if ({taken_count, redirect} !== {32'hFFFF_FFFF, 1'b1}) begin
            n_fail++;
            $display("FAIL taken_saturate: got tc=%h redir=%0b, want ffffffff 1", taken_count, redirect);
        end
        // Now in FLUSH: reset must abort it on the same edge.
        cycle(0, 0, 0, 0, 3'd0, 0, 0, 0, 1);
        n_tests++;
        if ({redirect, redirect_pc, flush_if_id, flush_id_ex, illegal_branch,
             branch_count, taken_count} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_in_flush: got redir=%0b pc=%h fl=%0b%0b ill=%0b bc=%0d tc=%0d, want all zero",
                     redirect, redirect_pc, flush_if_id, flush_id_ex, illegal_branch,
                     branch_count, taken_count);
        end
        // Back in RUN: a taken branch is accepted immediately.
        cycle(1, 0, 1, 0, 3'd1, 32'd1, 32'd2, 32'h700, 0);
        n_tests++;
        if ({redirect, redirect_pc, taken_count} !== {1'b1, 32'h700, 32'd1}) begin
            n_fail++;
            $display("FAIL run_after_reset: got redir=%0b pc=%h tc=%0d, want 1 00000700 1",
                     redirect, redirect_pc, taken_count);
        end
    endtask

    initial begin
        test_reset();
        test_beq_taken();
        test_unsigned_rs2_zero();
        test_blt_overflow();
        test_back_to_back();
        test_illegal();
        test_random();
        test_saturation_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
